seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 8-digit 7-segment scan into a 32-bit BCD-style frame.
// Optional macro SEG_DEC_DP_EN adds a dp_out[7:0] port carrying the per-digit decimal points.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_en,
    input  logic [7:0]  seg_out,
    input  logic        clr_err,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        pat_err,
    output logic        en_err,
    output logic        stale
`ifdef SEG_DEC_DP_EN
    ,
    output logic [7:0]  dp_out
`endif
);

    typedef enum logic [1:0] {WAIT, COUNT, HOLD} state_t;

`ifdef SEG_DEC_DP_EN
    localparam int unsigned SMP_W = 16;
    logic [SMP_W-1:0] smp_in;
    logic [7:0]       dp_shadow;
    assign smp_in = {seg_en, seg_out};
`else
    // Without dp support bit 7 never enters the sample, so dp toggles are invisible.
    localparam int unsigned SMP_W = 15;
    logic [SMP_W-1:0] smp_in;
    logic             unused_dp;
    assign smp_in    = {seg_en, seg_out[6:0]};
    assign unused_dp = seg_out[7];
`endif

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [8:0]    STABLE_9 = 9'(STABLE_CYC);

    state_t           state;
    logic [SMP_W-1:0] smp_q;
    logic [7:0]       cnt;
    logic [7:0]       mask;
    logic [31:0]      shadow;
    logic [TW-1:0]    tcnt;

    logic [7:0] en_q;
    logic       in_onehot, in_blank, in_chg;
    logic [8:0] cnt_nxt;
    logic       cap_en, en_evt, pat_evt, frame_done;
    logic [2:0] cap_slot;
    logic [3:0] cap_val;
    logic [7:0] mask_nxt;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   seg_decode = 4'h0;
            7'h79:   seg_decode = 4'h1;
            7'h24:   seg_decode = 4'h2;
            7'h30:   seg_decode = 4'h3;
            7'h19:   seg_decode = 4'h4;
            7'h12:   seg_decode = 4'h5;
            7'h02:   seg_decode = 4'h6;
            7'h78:   seg_decode = 4'h7;
            7'h00:   seg_decode = 4'h8;
            7'h10:   seg_decode = 4'h9;
            7'h7F:   seg_decode = 4'hE;
            default: seg_decode = 4'hF;
        endcase
    endfunction

    function automatic logic [2:0] slot_of(input logic [7:0] en);
        slot_of = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!en[i]) slot_of = 3'(i);
        end
    endfunction

    assign en_q = smp_q[SMP_W-1 -: 8];

    always_comb begin
        in_onehot  = $onehot(~seg_en);
        in_blank   = (seg_en == 8'hFF);
        in_chg     = (smp_in != smp_q);
        cnt_nxt    = {1'b0, cnt} + 9'd1;
        cap_en     = (state == COUNT) && !in_chg && (cnt_nxt >= STABLE_9);
        // Unchanged input in COUNT/HOLD is always one-hot, so this only fires on real events.
        en_evt     = !in_onehot && !in_blank;
        cap_slot   = slot_of(en_q);
        cap_val    = seg_decode(smp_q[6:0]);
        pat_evt    = cap_en && (cap_val == 4'hF);
        frame_done = (mask == 8'hFF);
        mask_nxt   = frame_done ? '0 : mask;
        if (cap_en) mask_nxt = mask_nxt | (8'b1 << cap_slot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT;
            smp_q       <= '0;
            cnt         <= '0;
            mask        <= '0;
            shadow      <= '0;
            digits      <= '0;
            frame_valid <= 1'b0;
            pat_err     <= 1'b0;
            en_err      <= 1'b0;
            stale       <= 1'b0;
            tcnt        <= '0;
`ifdef SEG_DEC_DP_EN
            dp_shadow   <= '0;
            dp_out      <= '0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (in_onehot) begin
                        state <= COUNT;
                        smp_q <= smp_in;
                        cnt   <= 8'd1;
                    end
                end
                COUNT: begin
                    if (in_chg) begin
                        if (in_onehot) begin
                            smp_q <= smp_in;
                            cnt   <= 8'd1;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end else if (cap_en) begin
                        state <= HOLD;
                    end else begin
                        cnt <= cnt_nxt[7:0];
                    end
                end
                HOLD: begin
                    if (in_chg) begin
                        if (in_onehot) begin
                            state <= COUNT;
                            smp_q <= smp_in;
                            cnt   <= 8'd1;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                default: state <= WAIT;
            endcase

            if (cap_en) begin
                shadow[4*cap_slot +: 4] <= cap_val;
`ifdef SEG_DEC_DP_EN
                dp_shadow[cap_slot] <= ~smp_q[7];
`endif
            end
            mask <= mask_nxt;

            frame_valid <= frame_done;
            if (frame_done) begin
                digits <= shadow;
`ifdef SEG_DEC_DP_EN
                dp_out <= dp_shadow;
`endif
            end

            pat_err <= (pat_err && !clr_err) || pat_evt;
            en_err  <= (en_err && !clr_err) || en_evt;

            if (frame_done) begin
                tcnt  <= '0;
                stale <= 1'b0;
            end else if (tcnt != TO_MAX) begin
                tcnt <= tcnt + TW'(1);
                if (tcnt + TW'(1) == TO_MAX) stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: frame vector table, hand-written corner
// sequences and randomized frames against a table-lookup reference model.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        clr_err;
    logic [31:0] digits;
    logic        frame_valid;
    logic        pat_err;
    logic        en_err;
    logic        stale;
`ifdef SEG_DEC_DP_EN
    logic [7:0]  dp_out;
    logic [7:0]  fv_dp;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned fv_count = 0;
    logic [31:0] fv_digits = '0;
    logic        fv_stale  = 1'b0;
    logic [31:0] prev_digits = '0;

    seg_scan_decoder #(
        .STABLE_CYC (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_en     (seg_en),
        .seg_out    (seg_out),
        .clr_err    (clr_err),
        .digits     (digits),
        .frame_valid(frame_valid),
        .pat_err    (pat_err),
        .en_err     (en_err),
        .stale      (stale)
`ifdef SEG_DEC_DP_EN
        ,
        .dp_out     (dp_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame monitor, plus a rule check that digits only move with frame_valid.
    always @(posedge clk) begin
        #1;
        if (frame_valid) begin
            fv_count++;
            fv_digits = digits;
            fv_stale  = stale;
`ifdef SEG_DEC_DP_EN
            fv_dp = dp_out;
`endif
        end
        if (!rst && !frame_valid) chk("digits_hold", digits, prev_digits);
        prev_digits = digits;
    end

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 10; i++) if (p == tbl[i]) return 4'(i);
        if (p == 7'h7F) return 4'hE;
        return 4'hF;
    endfunction

    function automatic logic [7:0] rand_pat();
        logic [6:0] tbl [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
        logic [6:0] p;
        if ($urandom_range(0, 3) == 0) p = 7'($urandom);
        else p = tbl[$urandom_range(0, 10)];
        return {1'($urandom), p};
    endfunction

    task automatic show(input int unsigned d, input logic [7:0] seg, input int unsigned n);
        seg_en  = ~(8'd1 << d);
        seg_out = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int unsigned n);
        seg_en  = '1;
        seg_out = '1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clr_err = 1'b0; seg_en = '1; seg_out = '1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        blank(1);
        clr_err = 1'b0;
    endtask

    task automatic scan_frame(input logic [7:0][6:0] pats);
        for (int d = 0; d < 8; d++) begin
            show(d, {1'b1, pats[d]}, 10);
            blank(2);
        end
    endtask

    typedef struct {
        logic [7:0][6:0] pats;
        logic [31:0]     exp_d;
        logic            exp_pe;
    } vec_t;

    localparam logic [7:0][6:0] P18 = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        vec_t        vecs [4];
        int unsigned n0;
        int unsigned perm [8];
        logic [31:0] exp_d;
        logic [7:0]  exp_dp;
        logic        exp_pe;

        vecs[0] = '{pats: P18, exp_d: 32'h87654321, exp_pe: 1'b0};
        vecs[1] = '{pats: {7'h24, 7'h30, 7'h55, 7'h78, 7'h02, 7'h7F, 7'h10, 7'h40},
                    exp_d: 32'h23F76E90, exp_pe: 1'b1};
        vecs[2] = '{pats: {8{7'h00}}, exp_d: 32'h88888888, exp_pe: 1'b0};
        vecs[3] = '{pats: {7'h78, 7'h10, 7'h7F, 7'h12, 7'h79, 7'h40, 7'h41, 7'h19},
                    exp_d: 32'h79E510F4, exp_pe: 1'b1};

        rst = 1'b1; clr_err = 1'b0; seg_en = '1; seg_out = '1;
        do_reset();
        chk("rst_digits", digits, 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_pat_err", 32'(pat_err), 32'h0);
        chk("rst_en_err", 32'(en_err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);

        // Table-driven full frames.
        for (int v = 0; v < 4; v++) begin
            clr_pulse();
            n0 = fv_count;
            scan_frame(vecs[v].pats);
            chk($sformatf("vec%0d_fv", v), fv_count - n0, 32'd1);
            chk($sformatf("vec%0d_digits", v), fv_digits, vecs[v].exp_d);
            chk($sformatf("vec%0d_pat_err", v), 32'(pat_err), 32'(vecs[v].exp_pe));
`ifdef SEG_DEC_DP_EN
            chk($sformatf("vec%0d_dp", v), 32'(fv_dp), 32'h0);
`endif
        end

        // Latency: final capture on the 4th stable clock, frame_valid on the 5th.
        do_reset();
        for (int d = 0; d < 7; d++) begin
            show(d, {1'b1, P18[d]}, 10);
            blank(2);
        end
        seg_en = 8'h7F; seg_out = {1'b1, P18[7]};
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_fv_clk%0d", k), 32'(frame_valid), 32'(k == 5));
        end
        @(negedge clk);
        blank(2);
        chk("lat_digits", digits, 32'h87654321);

        // Digit 3 held only 3 clocks is not captured.
        do_reset();
        n0 = fv_count;
        show(3, {1'b1, P18[3]}, 3);
        blank(2);
        for (int d = 0; d < 8; d++) begin
            if (d != 3) begin
                show(d, {1'b1, P18[d]}, 10);
                blank(2);
            end
        end
        chk("short_no_frame", fv_count - n0, 32'd0);
        show(3, {1'b1, P18[3]}, 10);
        blank(2);
        chk("short_then_frame", fv_count - n0, 32'd1);
        chk("short_digits", fv_digits, 32'h87654321);

        // Two enables low: error, no capture; clr_err clears; event beats clear.
        do_reset();
        n0 = fv_count;
        seg_en = 8'hFC; seg_out = 8'hF9;
        repeat (5) @(negedge clk);
        chk("multi_en_err", 32'(en_err), 32'h1);
        blank(2);
        for (int d = 2; d < 8; d++) begin
            show(d, {1'b1, P18[d]}, 10);
            blank(2);
        end
        chk("multi_no_capture", fv_count - n0, 32'd0);
        clr_err = 1'b1;
        @(posedge clk); #1;
        chk("clr_en_err", 32'(en_err), 32'h0);
        @(negedge clk);
        seg_en = 8'hFC;
        @(posedge clk); #1;
        chk("clr_vs_event", 32'(en_err), 32'h1);
        @(negedge clk);
        clr_err = 1'b0;
        blank(2);

        // Reset mid-frame discards partial captures.
        do_reset();
        n0 = fv_count;
        for (int d = 0; d < 4; d++) begin
            show(d, 8'h90, 10);
            blank(2);
        end
        do_reset();
        scan_frame(P18);
        chk("midrst_fv", fv_count - n0, 32'd1);
        chk("midrst_digits", fv_digits, 32'h87654321);

        // Timeout: stale at exactly 100 idle clocks, held, cleared with frame_valid.
        do_reset();
        repeat (99) @(posedge clk);
        #1 chk("stale_99", 32'(stale), 32'h0);
        @(posedge clk);
        #1 chk("stale_100", 32'(stale), 32'h1);
        @(negedge clk);
        repeat (20) @(negedge clk);
        chk("stale_hold", 32'(stale), 32'h1);
        n0 = fv_count;
        scan_frame(P18);
        chk("stale_fv", fv_count - n0, 32'd1);
        chk("stale_at_fv", 32'(fv_stale), 32'h0);

        // Randomized frames with glitches, re-captures and varying gaps.
        do_reset();
        for (int f = 0; f < 30; f++) begin
            logic [7:0]  seg;
            logic [3:0]  nib;
            int unsigned d;
            clr_pulse();
            exp_pe = 1'b0;
            exp_d  = '0;
            exp_dp = '0;
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int unsigned j, t;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            n0 = fv_count;
            for (int v = 0; v < 9; v++) begin
                d   = (v < 2) ? perm[0] : perm[v-1];
                seg = rand_pat();
                if ($urandom_range(0, 2) == 0)
                    show(d, seg ^ {1'b0, 7'($urandom_range(1, 127))}, $urandom_range(1, 3));
                show(d, seg, $urandom_range(4, 8));
                blank($urandom_range(0, 2));
                nib = ref_decode(seg[6:0]);
                exp_d[4*d +: 4] = nib;
                exp_dp[d] = ~seg[7];
                if (nib == 4'hF) exp_pe = 1'b1;
            end
            blank(2);
            chk($sformatf("rnd%0d_fv", f), fv_count - n0, 32'd1);
            chk($sformatf("rnd%0d_digits", f), fv_digits, exp_d);
            chk($sformatf("rnd%0d_pat_err", f), 32'(pat_err), 32'(exp_pe));
`ifdef SEG_DEC_DP_EN
            chk($sformatf("rnd%0d_dp", f), 32'(fv_dp), 32'(exp_dp));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
